logic_unit_arbiter: RTL

//   Shares one 16-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters:

---
 rtl/logic_unit_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/logic_unit_arbiter.sv
// Shared 16-bit bitwise logic unit (AND/OR/XOR/NOR) arbitrated between two requesters.
// Per-cycle grant (round-robin or fixed priority), one registered result stage with valid/ready.
module logic_unit_arbiter #(
  parameter int unsigned WIDTH      = 16,
  parameter bit          PRIO_FIXED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_src,
  output logic             res_zero,
  output logic [15:0]      ops_done
);

  localparam int unsigned CntW = 16;

  typedef enum logic [1:0] {
    OpAnd = 2'b00,
    OpOr  = 2'b01,
    OpXor = 2'b10,
    OpNor = 2'b11
  } opE;

  typedef enum logic {
    Empty = 1'b0,
    Full  = 1'b1
  } stateE;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } reqT;

  stateE            state;
  logic             lastGrant;
  logic [WIDTH-1:0] resData;
  logic             resSrc;
  logic             resZero;
  logic [CntW-1:0]  opsDone;

  logic             canAccept;
  logic             bothValid;
  logic             anyValid;
  logic             grantSel;
  logic             take;
  reqT              req0;
  reqT              req1;
  reqT              selReq;
  logic [WIDTH-1:0] andV;
  logic [WIDTH-1:0] orV;
  logic [WIDTH-1:0] xorV;
  logic [WIDTH-1:0] aluOut;

  assign req0 = '{op: req0_op, a: req0_a, b: req0_b};
  assign req1 = '{op: req1_op, a: req1_a, b: req1_b};

  // Result slot can take a new value when empty or being drained this cycle
  assign canAccept = (state == Empty) | res_ready;
  assign bothValid = req0_valid & req1_valid;
  assign anyValid  = req0_valid | req1_valid;

  always_comb begin
    grantSel = req1_valid;
    if (bothValid) begin
      grantSel = PRIO_FIXED ? 1'b0 : ~lastGrant;
    end
  end

  // rst_n gating keeps both readies low for the whole reset window
  assign take       = canAccept & anyValid & rst_n;
  assign req0_ready = take & ~grantSel;
  assign req1_ready = take & grantSel;

  assign selReq = grantSel ? req1 : req0;

  assign andV = selReq.a & selReq.b;
  assign orV  = selReq.a | selReq.b;
  assign xorV = selReq.a ^ selReq.b;

  always_comb begin
    aluOut = andV;
    case (opE'(selReq.op))
      OpAnd:   aluOut = andV;
      OpOr:    aluOut = orV;
      OpXor:   aluOut = xorV;
      OpNor:   aluOut = ~orV;
      default: aluOut = andV;
    endcase
  end

  // Result-stage FSM; a transfer always (re)fills, otherwise a consumed result empties the slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= Empty;
      lastGrant <= 1'b1;
      resData   <= '0;
      resSrc    <= 1'b0;
      resZero   <= 1'b1;
    end else if (take) begin
      state     <= Full;
      lastGrant <= grantSel;
      resData   <= aluOut;
      resSrc    <= grantSel;
      resZero   <= (aluOut == '0);
    end else if (res_ready) begin
      state     <= Empty;
    end
  end

  // Saturating count of consumed results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opsDone <= '0;
    end else if ((state == Full) && res_ready && (opsDone != {CntW{1'b1}})) begin
      opsDone <= opsDone + CntW'(1);
    end
  end

  assign res_valid = (state == Full);
  assign res_data  = resData;
  assign res_src   = resSrc;
  assign res_zero  = resZero;
  assign ops_done  = opsDone;

endmodule
